// File: rtl/serdes_square_tx.sv
// serdes_square_tx: square-wave word generator for an 8:1 DDR output serializer.
// Each clock produces 8 serial samples (bit 7 first) of a 50% duty square wave
// whose half-period is counted in bit-times. Half-period updates arrive through
// a valid/ready handshake and take effect only at a rising edge of the wave.
module serdes_square_tx #(
  parameter int PERIOD_BITS = 16,
  parameter int RESET_HALF  = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   ENABLE,
  input  logic [PERIOD_BITS-1:0] HALF_PERIOD,
  input  logic                   HALF_PERIOD_VALID,
  output logic                   HALF_PERIOD_READY,
  output logic [7:0]             OUT,
  output logic                   EDGE,
  output logic [2:0]             EDGE_POS
);

  localparam logic [PERIOD_BITS-1:0] HALF_RST = PERIOD_BITS'(RESET_HALF);
  localparam logic [PERIOD_BITS-1:0] ONE      = {{(PERIOD_BITS-1){1'b0}}, 1'b1};

  // Architectural state
  logic [PERIOD_BITS-1:0] half_q, half_d;
  logic [PERIOD_BITS-1:0] pending_q, pending_d;
  logic                   pend_valid_q, pend_valid_d;
  logic                   level_q, level_d;
  // Bit-times left before the next toggle. A value of 0 means the toggle (and
  // its reload) is due on the very next bit-time; deferring the reload this way
  // lets a request accepted one cycle earlier catch an edge that falls exactly
  // on a word boundary.
  logic [PERIOD_BITS-1:0] remaining_q, remaining_d;
  logic                   prev_bit_q, prev_bit_d;
  logic                   en_q, en_d;
  logic [7:0]             out_q, out_d;
  logic                   edge_q, edge_d;
  logic [2:0]             edge_pos_q, edge_pos_d;

  // Chain temporaries
  logic [PERIOD_BITS-1:0] c_half, c_rem, req_half;
  logic                   c_lvl, c_pv;
  logic [7:0]             word;
  logic [8:0]             seq;
  logic                   found;
  logic [2:0]             pos;
  logic                   accept;

  assign accept   = HALF_PERIOD_VALID & ~pend_valid_q;
  // A zero request would stall the counter; treat it as the shortest half.
  assign req_half = (HALF_PERIOD == '0) ? ONE : HALF_PERIOD;

  // Unrolled 8-step bit-time chain building this cycle's word
  always_comb begin
    c_half = half_q;
    c_pv   = pend_valid_q;
    c_lvl  = level_q;
    c_rem  = remaining_q;
    word   = '0;
    // First enabled word starts high; that leading rising edge is also an
    // edge at which a pending half-period may be taken.
    if (!en_q) begin
      c_lvl = 1'b1;
      if (c_pv) begin
        c_half = pending_q;
        c_pv   = 1'b0;
      end
      c_rem = c_half;
    end
    for (int i = 0; i < 8; i++) begin
      if (c_rem == '0) begin
        c_lvl = ~c_lvl;
        if (c_lvl && c_pv) begin
          c_half = pending_q;
          c_pv   = 1'b0;
        end
        c_rem = c_half;
      end
      word[7-i] = c_lvl;
      c_rem     = c_rem - ONE;
    end
  end

  // First 0->1 transition across the previous word's last bit and this word
  always_comb begin
    seq   = {prev_bit_q, word};
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < 8; i++) begin
      if (!found && !seq[8-i] && seq[7-i]) begin
        found = 1'b1;
        pos   = 3'(i);
      end
    end
  end

  // Next-state selection for enabled, idle and handshake paths
  always_comb begin
    half_d       = half_q;
    pending_d    = accept ? req_half : pending_q;
    pend_valid_d = pend_valid_q | accept;
    level_d      = level_q;
    remaining_d  = remaining_q;
    prev_bit_d   = prev_bit_q;
    en_d         = ENABLE;
    out_d        = '0;
    edge_d       = 1'b0;
    edge_pos_d   = '0;
    if (ENABLE) begin
      half_d       = c_half;
      pend_valid_d = c_pv | accept;
      level_d      = c_lvl;
      remaining_d  = c_rem;
      prev_bit_d   = word[0];
      out_d        = word;
      edge_d       = found;
      edge_pos_d   = pos;
    end else begin
      // Idle: no phase to protect, so a pending half is taken at once.
      if (pend_valid_q) begin
        half_d       = pending_q;
        pend_valid_d = 1'b0;
      end
      level_d     = 1'b0;
      prev_bit_d  = 1'b0;
      remaining_d = half_d;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      half_q       <= HALF_RST;
      pending_q    <= '0;
      pend_valid_q <= 1'b0;
      level_q      <= 1'b0;
      remaining_q  <= HALF_RST;
      prev_bit_q   <= 1'b0;
      en_q         <= 1'b0;
      out_q        <= '0;
      edge_q       <= 1'b0;
      edge_pos_q   <= '0;
    end else begin
      half_q       <= half_d;
      pending_q    <= pending_d;
      pend_valid_q <= pend_valid_d;
      level_q      <= level_d;
      remaining_q  <= remaining_d;
      prev_bit_q   <= prev_bit_d;
      en_q         <= en_d;
      out_q        <= out_d;
      edge_q       <= edge_d;
      edge_pos_q   <= edge_pos_d;
    end
  end

  assign HALF_PERIOD_READY = ~pend_valid_q;
  assign OUT               = out_q;
  assign EDGE              = edge_q;
  assign EDGE_POS          = edge_pos_q;

endmodule

// File: tb/tb_serdes_square_tx.sv
// Directed bench for serdes_square_tx: hand-computed words, edge flags and
// handshake behaviour, checked with immediate assertions.
module tb_serdes_square_tx;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic [15:0] HALF_PERIOD;
  logic        HALF_PERIOD_VALID;
  logic        HALF_PERIOD_READY;
  logic [7:0]  OUT;
  logic        EDGE;
  logic [2:0]  EDGE_POS;

  int total = 0;
  int bad   = 0;

  serdes_square_tx #(.PERIOD_BITS(16), .RESET_HALF(8)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .ENABLE            (ENABLE),
    .HALF_PERIOD       (HALF_PERIOD),
    .HALF_PERIOD_VALID (HALF_PERIOD_VALID),
    .HALF_PERIOD_READY (HALF_PERIOD_READY),
    .OUT               (OUT),
    .EDGE              (EDGE),
    .EDGE_POS          (EDGE_POS)
  );

  always #5 CLK = ~CLK;

  // Advance one clock; outputs are then settled for the cycle just entered.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [7:0] w, input logic e, input logic [2:0] p);
    chk({tag, ".out"}, 16'(OUT), 16'(w));
    chk({tag, ".edge"}, 16'(EDGE), 16'(e));
    chk({tag, ".pos"}, 16'(EDGE_POS), 16'(p));
  endtask

  // Request a half-period while idle, then enable on the following cycle.
  task automatic load_idle(input logic [15:0] h);
    ENABLE            = 1'b0;
    HALF_PERIOD       = h;
    HALF_PERIOD_VALID = 1'b1;
    tick();
    HALF_PERIOD_VALID = 1'b0;
    chk("idle.out", 16'(OUT), 16'h00);
    chk("idle.ready_low", 16'(HALF_PERIOD_READY), 16'h0);
    tick();
    chk("idle.ready_back", 16'(HALF_PERIOD_READY), 16'h1);
    ENABLE = 1'b1;
  endtask

  initial begin
    RESET             = 1'b1;
    ENABLE            = 1'b0;
    HALF_PERIOD       = '0;
    HALF_PERIOD_VALID = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
    tick();
    chk_word("rst", 8'h00, 1'b0, 3'd0);
    chk("rst.ready", 16'(HALF_PERIOD_READY), 16'h1);

    // Reset half of 8: one full word high, one full word low
    ENABLE = 1'b1;
    tick(); chk_word("h8.w0", 8'hFF, 1'b1, 3'd0);
    tick(); chk_word("h8.w1", 8'h00, 1'b0, 3'd0);
    tick(); chk_word("h8.w2", 8'hFF, 1'b1, 3'd0);
    tick(); chk_word("h8.w3", 8'h00, 1'b0, 3'd0);

    // Half of 4
    load_idle(16'd4);
    for (int i = 0; i < 3; i++) begin
      tick(); chk_word("h4", 8'hF0, 1'b1, 3'd0);
    end

    // Live change 4 -> 2; a second VALID while READY=0 must be dropped
    HALF_PERIOD       = 16'd2;
    HALF_PERIOD_VALID = 1'b1;
    tick();
    chk_word("chg.k1", 8'hF0, 1'b1, 3'd0);
    chk("chg.ready_k1", 16'(HALF_PERIOD_READY), 16'h0);
    HALF_PERIOD = 16'd6;
    tick();
    HALF_PERIOD_VALID = 1'b0;
    chk_word("chg.k2", 8'hCC, 1'b1, 3'd0);
    chk("chg.ready_k2", 16'(HALF_PERIOD_READY), 16'h1);
    for (int i = 0; i < 3; i++) begin
      tick(); chk_word("chg.cc", 8'hCC, 1'b1, 3'd0);
      chk("chg.ready", 16'(HALF_PERIOD_READY), 16'h1);
    end

    // Disable: output idles next cycle
    ENABLE = 1'b0;
    tick(); chk_word("dis", 8'h00, 1'b0, 3'd0);

    // Half of 3: three-word cycle with moving edge position
    load_idle(16'd3);
    tick(); chk_word("h3.w0", 8'hE3, 1'b1, 3'd0);
    tick(); chk_word("h3.w1", 8'h8E, 1'b1, 3'd4);
    tick(); chk_word("h3.w2", 8'h38, 1'b1, 3'd2);
    tick(); chk_word("h3.w3", 8'hE3, 1'b1, 3'd0);

    // Half of 0 behaves as 1
    load_idle(16'd0);
    tick(); chk_word("h0.w0", 8'hAA, 1'b1, 3'd0);
    tick(); chk_word("h0.w1", 8'hAA, 1'b1, 3'd0);

    // Reset while a half of 5 is still pending
    ENABLE = 1'b0;
    RESET  = 1'b1;
    tick();
    RESET = 1'b0;
    tick();
    ENABLE            = 1'b1;
    HALF_PERIOD       = 16'd5;
    HALF_PERIOD_VALID = 1'b1;
    tick();
    HALF_PERIOD_VALID = 1'b0;
    chk_word("pr.w0", 8'hFF, 1'b1, 3'd0);
    chk("pr.ready", 16'(HALF_PERIOD_READY), 16'h0);
    RESET  = 1'b1;
    ENABLE = 1'b0;
    tick();
    RESET = 1'b0;
    chk_word("pr.rst", 8'h00, 1'b0, 3'd0);
    chk("pr.rst_ready", 16'(HALF_PERIOD_READY), 16'h1);
    ENABLE = 1'b1;
    tick(); chk_word("pr.e0", 8'hFF, 1'b1, 3'd0);
    tick(); chk_word("pr.e1", 8'h00, 1'b0, 3'd0);
    tick(); chk_word("pr.e2", 8'hFF, 1'b1, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
